// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage load/store unit: funct3 access encodings,
// FSM state type and the default bus watchdog limit.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int TIMEOUT_CYCLES_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   // Unlisted funct3 codes (011/110/111) fall into the word case.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3)
         F3_B, F3_BU: is_misaligned = 1'b0;
         F3_H, F3_HU: is_misaligned = lo[0];
         default:     is_misaligned = (lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the M stage (master) and the memory (slave).
interface mem_access_stage_if #(parameter int word_width = 32);

   logic                  dmem_req;
   logic                  dmem_we;
   logic [word_width-1:0] dmem_addr;
   logic [3:0]            dmem_be;
   logic [word_width-1:0] dmem_wdata;
   logic                  dmem_ack;
   logic [word_width-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte-enables/replicated write data, and
// load byte/half extraction with sign or zero extension.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (st_funct3)
         F3_B, F3_BU: begin
            st_be    = 4'b0001 << st_addr_lo;
            st_wdata = {4{st_data[7:0]}};
         end
         F3_H, F3_HU: begin
            st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (ld_addr_lo)
         2'd0:    ld_byte = ld_word[7:0];
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

      case (ld_funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data = {24'd0, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data = {16'd0, ld_half};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// M-stage load/store unit: one req/ack data-memory transaction per access, stalling
// the pipeline until the response cycle. Optional watchdog: define MEM_TIMEOUT_EN.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int word_width = 32
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [2:0]            Funct3M,
   input  logic [word_width-1:0] ALUResultM,
   input  logic [word_width-1:0] WriteDataM,
   output logic [word_width-1:0] ReadDataM,
   output logic                  StallM,
   output logic                  MisalignedM,
`ifdef MEM_TIMEOUT_EN
   output logic                  BusErrM,
`endif
   mem_access_stage_if.master    dmem
);

   // state | meaning
   // IDLE  | waiting for a load/store; latches the access when one is presented
   // REQ   | dmem_req high, bus outputs frozen, waiting for dmem_ack
   // RESP  | response cycle; stall released so the pipeline advances

   mem_state_t state, state_n;

   logic [word_width-1:0] addr_q, wdata_q, rdata_q;
   logic [3:0]            be_q;
   logic                  we_q;
   logic [2:0]            f3_q;
   logic [1:0]            lo_q;

   logic                  access, misaligned;
   logic                  stall, mis_flag, capture, load_done;
   logic [3:0]            st_be;
   logic [31:0]           st_wdata, ld_data;

   assign access     = MemReadM | MemWriteM;
   assign misaligned = is_misaligned(Funct3M, ALUResultM[1:0]);

   mem_lane_align u_lane (
      .st_funct3  (Funct3M),
      .st_addr_lo (ALUResultM[1:0]),
      .st_data    (WriteDataM),
      .st_be      (st_be),
      .st_wdata   (st_wdata),
      .ld_funct3  (f3_q),
      .ld_addr_lo (lo_q),
      .ld_word    (dmem.dmem_rdata),
      .ld_data    (ld_data)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   logic          timeout, bus_err_q;
`endif

   always_comb begin
      state_n   = state;
      stall     = 1'b0;
      mis_flag  = 1'b0;
      capture   = 1'b0;
      load_done = 1'b0;
`ifdef MEM_TIMEOUT_EN
      timeout   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (access) begin
               if (misaligned) begin
                  mis_flag = 1'b1;
               end else begin
                  stall   = 1'b1;
                  capture = 1'b1;
                  state_n = REQ;
               end
            end
         end
         REQ: begin
            stall = 1'b1;
            if (dmem.dmem_ack) begin
               load_done = ~we_q;
               state_n   = RESP;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               timeout = 1'b1;
               state_n = RESP;
            end
`endif
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= 4'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         lo_q    <= 2'd0;
         rdata_q <= '0;
      end else begin
         state <= state_n;
         if (capture) begin
            addr_q  <= {ALUResultM[word_width-1:2], 2'b00};
            wdata_q <= st_wdata;
            be_q    <= st_be;
            we_q    <= MemWriteM;
            f3_q    <= Funct3M;
            lo_q    <= ALUResultM[1:0];
         end
         if (load_done) rdata_q <= ld_data;
`ifdef MEM_TIMEOUT_EN
         if (timeout) rdata_q <= '0;
`endif
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         bus_err_q <= 1'b0;
      end else begin
         if (capture)           cnt <= '0;
         else if (state == REQ) cnt <= cnt + 1'b1;
         bus_err_q <= timeout;
      end
   end

   assign BusErrM = bus_err_q;
`endif

   // Gated by rst_n so a load held in EX/M during reset does not raise a stall.
   assign StallM      = rst_n & stall;
   assign MisalignedM = rst_n & mis_flag;
   assign ReadDataM   = rdata_q;

   assign dmem.dmem_req   = (state == REQ);
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_be    = be_q;
   assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; covers the watchdog path
// when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemReadM, MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   wire  [31:0] ReadDataM;
   wire         StallM, MisalignedM;
`ifdef MEM_TIMEOUT_EN
   wire         BusErrM;
`endif

   mem_access_stage_if bus ();

   mem_access_stage #(
      .word_width (32)
`ifdef MEM_TIMEOUT_EN
      , .TIMEOUT_CYCLES (4)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .MemReadM    (MemReadM),
      .MemWriteM   (MemWriteM),
      .Funct3M     (Funct3M),
      .ALUResultM  (ALUResultM),
      .WriteDataM  (WriteDataM),
      .ReadDataM   (ReadDataM),
      .StallM      (StallM),
      .MisalignedM (MisalignedM),
`ifdef MEM_TIMEOUT_EN
      .BusErrM     (BusErrM),
`endif
      .dmem        (bus.master)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int          stalls, unstable, req_cycles;
   bit          done;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_we;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one access, acks after 'waits' unacked REQ cycles, returns in the RESP cycle.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rword, input int waits);
      int  w;
      bit  seen;
      w = 0; seen = 0; stalls = 0; unstable = 0; done = 0;
      MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
      for (int i = 0; i < 50 && !done; i++) begin
         #1;
         if (StallM) stalls++;
         if (bus.dmem_req) begin
            if (!seen) begin
               cap_addr = bus.dmem_addr; cap_be = bus.dmem_be;
               cap_we = bus.dmem_we; cap_wdata = bus.dmem_wdata;
               seen = 1;
            end else if ({cap_addr, cap_be, cap_we, cap_wdata} !==
                         {bus.dmem_addr, bus.dmem_be, bus.dmem_we, bus.dmem_wdata}) begin
               unstable++;
            end
            if (w == waits) begin
               bus.dmem_ack = 1'b1; bus.dmem_rdata = rword;
            end else begin
               w++;
            end
         end else if (seen && !StallM) begin
            done = 1;
         end
         if (!done) tick();
      end
      check("txn_completed", {31'd0, done}, 32'd1);
      check("bus_stable_in_req", unstable, 32'd0);
      MemReadM = 0; MemWriteM = 0; bus.dmem_ack = 0; bus.dmem_rdata = 32'hDEAD_DEAD;
   endtask

   initial begin
      rst_n = 0; MemReadM = 0; MemWriteM = 0; Funct3M = 3'b000;
      ALUResultM = 0; WriteDataM = 0;
      bus.dmem_ack = 0; bus.dmem_rdata = 32'hDEAD_DEAD;
      #12;
      check("rst_readdata", ReadDataM, 32'd0);
      check("rst_stall", {31'd0, StallM}, 32'd0);
      check("rst_misaligned", {31'd0, MisalignedM}, 32'd0);
      check("rst_req", {31'd0, bus.dmem_req}, 32'd0);
      check("rst_we", {31'd0, bus.dmem_we}, 32'd0);
      check("rst_addr", bus.dmem_addr, 32'd0);
      check("rst_be", {28'd0, bus.dmem_be}, 32'd0);
      check("rst_wdata", bus.dmem_wdata, 32'd0);
      rst_n = 1;
      tick();

      // LB 0x103, ack in first REQ cycle
      run_access(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
      check("lb_addr", cap_addr, 32'h0000_0100);
      check("lb_be", {28'd0, cap_be}, 32'h8);
      check("lb_we", {31'd0, cap_we}, 32'd0);
      check("lb_data", ReadDataM, 32'hFFFF_FF80);
      check("lb_stalls", stalls, 32'd2);
      tick();

      // LHU 0x202, three wait cycles
      run_access(1, 0, 3'b101, 32'h0000_0202, 32'h0, 32'h9ABC_5678, 3);
      check("lhu_addr", cap_addr, 32'h0000_0200);
      check("lhu_be", {28'd0, cap_be}, 32'hC);
      check("lhu_data", ReadDataM, 32'h0000_9ABC);
      check("lhu_stalls", stalls, 32'd5);
      tick();

      // SH 0x302: ReadDataM must not change
      run_access(0, 1, 3'b001, 32'h0000_0302, 32'h1111_BEEF, 32'h5555_AAAA, 0);
      check("sh_we", {31'd0, cap_we}, 32'd1);
      check("sh_addr", cap_addr, 32'h0000_0300);
      check("sh_be", {28'd0, cap_be}, 32'hC);
      check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
      check("sh_readdata_held", ReadDataM, 32'h0000_9ABC);
      check("sh_stalls", stalls, 32'd2);
      tick();

      // LW 0x401 misaligned
      MemReadM = 1; Funct3M = 3'b010; ALUResultM = 32'h0000_0401;
      #1;
      check("lw_mis_flag", {31'd0, MisalignedM}, 32'd1);
      check("lw_mis_stall", {31'd0, StallM}, 32'd0);
      tick();
      check("lw_mis_no_req", {31'd0, bus.dmem_req}, 32'd0);
      check("lw_mis_readdata", ReadDataM, 32'h0000_9ABC);
      // LH 0x203 misaligned
      Funct3M = 3'b001; ALUResultM = 32'h0000_0203;
      #1;
      check("lh_mis_flag", {31'd0, MisalignedM}, 32'd1);
      // Non-memory instruction
      MemReadM = 0;
      #1;
      check("nomem_stall", {31'd0, StallM}, 32'd0);
      check("nomem_mis", {31'd0, MisalignedM}, 32'd0);
      tick();

      // SB 0x101
      run_access(0, 1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0, 1);
      check("sb_be", {28'd0, cap_be}, 32'h2);
      check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
      check("sb_stalls", stalls, 32'd3);
      tick();

      // LH 0x106, upper half sign-extended
      run_access(1, 0, 3'b001, 32'h0000_0106, 32'h0, 32'h8001_7FFF, 0);
      check("lh_addr", cap_addr, 32'h0000_0104);
      check("lh_data", ReadDataM, 32'hFFFF_8001);
      tick();

      // LW 0x408
      run_access(1, 0, 3'b010, 32'h0000_0408, 32'h0, 32'h1234_5678, 2);
      check("lw_be", {28'd0, cap_be}, 32'hF);
      check("lw_data", ReadDataM, 32'h1234_5678);
      tick();

      // LBU 0x101, zero-extended
      run_access(1, 0, 3'b100, 32'h0000_0101, 32'h0, 32'h0000_8000, 0);
      check("lbu_be", {28'd0, cap_be}, 32'h2);
      check("lbu_data", ReadDataM, 32'h0000_0080);
      tick();

      // funct3 111 treated as SW
      run_access(0, 1, 3'b111, 32'h0000_050C, 32'hCAFE_F00D, 32'h0, 0);
      check("sw111_be", {28'd0, cap_be}, 32'hF);
      check("sw111_wdata", cap_wdata, 32'hCAFE_F00D);
      check("sw111_addr", cap_addr, 32'h0000_050C);
      check("sw111_readdata_held", ReadDataM, 32'h0000_0080);
      tick();

`ifdef MEM_TIMEOUT_EN
      // Watchdog: no ack for a load
      MemReadM = 1; Funct3M = 3'b010; ALUResultM = 32'h0000_0700;
      tick();
      req_cycles = 0;
      for (int i = 0; i < 20 && bus.dmem_req; i++) begin
         req_cycles++;
         check("to_buserr_low_in_req", {31'd0, BusErrM}, 32'd0);
         tick();
      end
      check("to_req_cycles", req_cycles, 32'd4);
      check("to_buserr", {31'd0, BusErrM}, 32'd1);
      check("to_readdata", ReadDataM, 32'd0);
      check("to_resp_stall", {31'd0, StallM}, 32'd0);
      MemReadM = 0;
      tick();
      check("to_buserr_clear", {31'd0, BusErrM}, 32'd0);
      check("to_idle_no_req", {31'd0, bus.dmem_req}, 32'd0);
      // Reload a nonzero value so the reset check below is meaningful
      run_access(1, 0, 3'b010, 32'h0000_0408, 32'h0, 32'h1234_5678, 0);
      tick();
`endif

      // Reset while REQ is outstanding
      MemReadM = 1; Funct3M = 3'b010; ALUResultM = 32'h0000_0600;
      tick();
      check("mid_rst_in_req", {31'd0, bus.dmem_req}, 32'd1);
      #2;
      rst_n = 0;
      #1;
      check("mid_rst_req_drop", {31'd0, bus.dmem_req}, 32'd0);
      check("mid_rst_stall", {31'd0, StallM}, 32'd0);
      check("mid_rst_readdata", ReadDataM, 32'd0);
      MemReadM = 0;
      bus.dmem_ack = 1; bus.dmem_rdata = 32'hFFFF_FFFF;
      tick();
      rst_n = 1;
      tick();
      check("late_ack_no_req", {31'd0, bus.dmem_req}, 32'd0);
      check("late_ack_readdata", ReadDataM, 32'd0);
      check("late_ack_stall", {31'd0, StallM}, 32'd0);
      bus.dmem_ack = 0;
      tick();
      check("late_ack_idle", {31'd0, bus.dmem_req}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory (M) stage load/store unit of the 5-stage pipeline.
- Takes the decoded memory operation held in the EX/M register and runs a req/ack transaction on the data-memory bus.
- Aligns and extends load data, then presents ReadDataM to the M/W register.
- Holds the pipeline with StallM while a transaction is outstanding.

Parameters:
- word_width, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 16, watchdog limit in REQ state; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- MemReadM  in  1  load in M stage.
- MemWriteM  in  1  store in M stage. MemReadM and MemWriteM are never both 1.
- Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultM  in  word_width  effective byte address.
- WriteDataM  in  word_width  store data (rs2).
- ReadDataM  out  word_width  aligned, extended load data to the M/W register.
- StallM  out  1  freeze PC, F/D, D/E, E/M and M/W registers.
- MisalignedM  out  1  misaligned access flag, valid the cycle the access is presented.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  word_width  word address; bits [1:0] are 00.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  word_width  lane-replicated store data.
- dmem_ack  in  1  transaction complete.
- dmem_rdata  in  word_width  read word, valid with dmem_ack.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, ReadDataM=0.
  - StallM=0, MisalignedM=0.
  - Reset mid-transaction drops dmem_req immediately; a late ack is ignored.
- Access = MemReadM|MemWriteM. Misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0.
- FSM:
  - IDLE:
    - If access and not misaligned: register addr/we/be/wdata/Funct3/addr[1:0]; StallM=1 (combinational); go to REQ.
    - If misaligned: MisalignedM=1 (combinational); no request; no stall; ReadDataM unchanged; stay in IDLE.
    - If no access: StallM=0; stay in IDLE.
  - REQ:
    - dmem_req=1; bus outputs held stable; StallM=1.
    - On dmem_ack: for loads, capture the formatted dmem_rdata into ReadDataM; go to RESP. Ack in the first REQ cycle is legal.
  - RESP:
    - StallM=0; dmem_req=0; go to IDLE. The pipeline advances at the end of this cycle.
- Latency:
  - Non-memory instruction: 0 stall cycles.
  - Load/store: 2 stall cycles minimum (IDLE, REQ), plus 1 per cycle without ack.
- Store formatting:
  - SB: be = 1<<addr[1:0], wdata = {4{b}}.
  - SH: be = 0011 or 1100 by addr[1], wdata = {2{h}}.
  - SW: be = 1111.
- Load formatting:
  - Byte/half selected by the latched addr[1:0].
  - B/H sign-extend; BU/HU zero-extend.
  - dmem_be is also driven on loads.
- Funct3 011/110/111 are treated as W/SW.
- ReadDataM holds its last value outside load completion. Stores never modify it.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to REQ, incremented each REQ cycle.
  - On reaching TIMEOUT_CYCLES without ack: drop req, ReadDataM=0, BusErrM=1 for the RESP cycle, go to RESP.
  - Adds port BusErrM out 1 (reset 0).
- Undefined: no counter and no BusErrM port; REQ waits indefinitely.

Decomposition:
- Package mem_pkg holds:
  - funct3 encoding constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - mem_state_t enum (IDLE, REQ, RESP).
  - Default TIMEOUT_CYCLES.
- One combinational sub-module, mem_lane_align: store lane/byte-enable generation and load extract/extend. Unit-testable separately.

Test Plan:
- Reset mid-REQ (rst_n low while dmem_req=1) -> dmem_req=0 same cycle, StallM=0, state IDLE; ack arriving afterward is ignored.
- LB at addr 0x103, dmem_rdata=0x80FF_1234, ack on first REQ cycle -> dmem_addr=0x100, be=0001... correction: be=1000, ReadDataM=0xFFFF_FF80, StallM high exactly 2 cycles.
- LHU at 0x202, rdata=0x9ABC_5678, ack after 3 wait cycles -> ReadDataM=0x0000_9ABC, StallM high 5 cycles.
- SH at 0x302, WriteDataM=0x1111_BEEF -> dmem_we=1, be=1100, wdata=0xBEEF_BEEF, ReadDataM unchanged.
- LW at 0x401 -> MisalignedM=1, dmem_req stays 0, StallM=0.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> after 4 REQ cycles BusErrM=1 for one cycle, ReadDataM=0, then IDLE.
